// File: rtl/axis_tdest_demux_param.sv
// AXI-Stream packet demultiplexer: routes whole packets to one of M_COUNT outputs by first-beat tdest.
// Out-of-range or disabled destinations are dropped and counted; single registered output slot.
module axis_tdest_demux_param #(
   parameter int M_COUNT            = 3,
   parameter int AXIS_DATA_WIDTH    = 64,
   parameter int AXIS_KEEP_WIDTH    = AXIS_DATA_WIDTH/8,
   parameter int AXIS_DEST_WIDTH    = 2,
   parameter int DROP_COUNTER_WIDTH = 32
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [AXIS_DATA_WIDTH-1:0]            s_axis_tdata,
   input  logic [AXIS_KEEP_WIDTH-1:0]            s_axis_tkeep,
   input  logic                                  s_axis_tvalid,
   output logic                                  s_axis_tready,
   input  logic                                  s_axis_tlast,
   input  logic [AXIS_DEST_WIDTH-1:0]            s_axis_tdest,
   output logic [M_COUNT*AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
   output logic [M_COUNT*AXIS_KEEP_WIDTH-1:0]    m_axis_tkeep,
   output logic [M_COUNT-1:0]                    m_axis_tvalid,
   input  logic [M_COUNT-1:0]                    m_axis_tready,
   output logic [M_COUNT-1:0]                    m_axis_tlast,
   input  logic [M_COUNT-1:0]                    cfg_port_enable,
   input  logic                                  cfg_rst_drop_counter,
   output logic [DROP_COUNTER_WIDTH-1:0]         drop_counter,
   output logic                                  stat_in_packet
);

   localparam int unsigned DEST_N = 1 << AXIS_DEST_WIDTH;

   typedef enum logic [1:0] {ST_IDLE, ST_FORWARD, ST_DROP} state_t;

   state_t                          state_q, state_d;
   logic [AXIS_DEST_WIDTH-1:0]      sel_q, sel_d;
   logic                            out_valid_q, out_valid_d;
   logic [AXIS_DATA_WIDTH-1:0]      out_data_q, out_data_d;
   logic [AXIS_KEEP_WIDTH-1:0]      out_keep_q, out_keep_d;
   logic                            out_last_q, out_last_d;
   logic [AXIS_DEST_WIDTH-1:0]      out_port_q, out_port_d;
   logic [DROP_COUNTER_WIDTH-1:0]   drop_cnt_q, drop_cnt_d;

   logic [DEST_N-1:0]               en_ext, rdy_ext;
   logic                            dest_ok, slot_busy, s_ready, accept;
   logic                            load, drop_inc;
   logic [AXIS_DEST_WIDTH-1:0]      load_port;

   // Zero-extension makes every tdest >= M_COUNT look like a disabled port.
   assign en_ext    = DEST_N'(cfg_port_enable);
   assign rdy_ext   = DEST_N'(m_axis_tready);
   assign dest_ok   = en_ext[s_axis_tdest];
   assign slot_busy = out_valid_q && !rdy_ext[out_port_q];

   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      load      = 1'b0;
      load_port = sel_q;
      drop_inc  = 1'b0;
      s_ready   = 1'b0;
      if (rst) s_ready = (state_q == ST_DROP) ? 1'b1 : !slot_busy;
      accept = s_axis_tvalid && s_ready;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (dest_ok) begin
                  load      = 1'b1;
                  load_port = s_axis_tdest;
                  sel_d     = s_axis_tdest;
                  state_d   = s_axis_tlast ? ST_IDLE : ST_FORWARD;
               end else begin
                  drop_inc = 1'b1;
                  state_d  = s_axis_tlast ? ST_IDLE : ST_DROP;
               end
            end
         end
         ST_FORWARD: begin
            if (accept) begin
               load = 1'b1;
               if (s_axis_tlast) state_d = ST_IDLE;
            end
         end
         ST_DROP: begin
            if (accept && s_axis_tlast) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output slot: drain and reload may happen in the same cycle, even across ports.
   always_comb begin
      out_valid_d = out_valid_q && !rdy_ext[out_port_q];
      out_data_d  = out_data_q;
      out_keep_d  = out_keep_q;
      out_last_d  = out_last_q;
      out_port_d  = out_port_q;
      if (load) begin
         out_valid_d = 1'b1;
         out_data_d  = s_axis_tdata;
         out_keep_d  = s_axis_tkeep;
         out_last_d  = s_axis_tlast;
         out_port_d  = load_port;
      end
   end

   // Saturating drop counter; clear wins over a simultaneous increment.
   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (cfg_rst_drop_counter)
         drop_cnt_d = '0;
      else if (drop_inc && (drop_cnt_q != '1))
         drop_cnt_d = drop_cnt_q + DROP_COUNTER_WIDTH'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         sel_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_keep_q  <= '0;
         out_last_q  <= 1'b0;
         out_port_q  <= '0;
         drop_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_keep_q  <= out_keep_d;
         out_last_q  <= out_last_d;
         out_port_q  <= out_port_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   assign s_axis_tready  = s_ready;
   assign drop_counter   = drop_cnt_q;
   assign stat_in_packet = rst && (state_q != ST_IDLE);

   for (genvar i = 0; i < M_COUNT; i++) begin : g_port
      assign m_axis_tvalid[i] = rst && out_valid_q && (out_port_q == AXIS_DEST_WIDTH'(i));
      assign m_axis_tdata[i*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH] = out_data_q;
      assign m_axis_tkeep[i*AXIS_KEEP_WIDTH +: AXIS_KEEP_WIDTH] = out_keep_q;
      assign m_axis_tlast[i] = out_last_q;
   end

endmodule

// File: tb/tb_axis_tdest_demux_param.sv
// Self-checking bench for axis_tdest_demux_param: directed scenarios then randomized packets,
// compared each cycle against an in-order packet-level scoreboard.
module tb_axis_tdest_demux_param;

   localparam int M   = 3;
   localparam int DW  = 64;
   localparam int KW  = 8;
   localparam int DSW = 2;
   localparam int CW  = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [DW-1:0]     s_tdata;
   logic [KW-1:0]     s_tkeep;
   logic              s_tvalid;
   logic              s_tready;
   logic              s_tlast;
   logic [DSW-1:0]    s_tdest;
   logic [M*DW-1:0]   m_tdata;
   logic [M*KW-1:0]   m_tkeep;
   logic [M-1:0]      m_tvalid;
   logic [M-1:0]      m_tready;
   logic [M-1:0]      m_tlast;
   logic [M-1:0]      cfg_en;
   logic              cfg_rst;
   logic [CW-1:0]     drop_cnt;
   logic              stat;

   always #5 clk = ~clk;

   axis_tdest_demux_param #(
      .M_COUNT(M), .AXIS_DATA_WIDTH(DW), .AXIS_KEEP_WIDTH(KW),
      .AXIS_DEST_WIDTH(DSW), .DROP_COUNTER_WIDTH(CW)
   ) dut (
      .clk(clk), .rst(rst),
      .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
      .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tdest(s_tdest),
      .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
      .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
      .cfg_port_enable(cfg_en), .cfg_rst_drop_counter(cfg_rst),
      .drop_counter(drop_cnt), .stat_in_packet(stat)
   );

   typedef struct {
      logic [1:0]    port;
      logic [DW-1:0] data;
      logic [KW-1:0] keep;
      logic          last;
   } beat_t;

   beat_t      expq[$];
   logic [2:0] rdy_pat[$];
   bit         rdy_rand;
   bit         in_pkt, fwd;
   logic [1:0] cur_port;
   logic [CW-1:0] cnt_m;
   int         tests = 0;
   int         fails = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: apply ready, check outputs at negedge, advance the model at the edge.
   task automatic cycle(output bit acc);
      logic [2:0] r;
      logic [2:0] ev;
      bit exp_rdy, drop_ev;
      if (rdy_pat.size() > 0) r = rdy_pat.pop_front();
      else if (rdy_rand)      r = 3'($urandom);
      else                    r = 3'b111;
      m_tready = r;
      @(negedge clk);
      ev = '0;
      if (rst && expq.size() > 0) ev[expq[0].port] = 1'b1;
      chk("tvalid", 64'(m_tvalid), 64'(ev));
      for (int p = 0; p < M; p++) begin
         if (ev[p]) begin
            chk("tdata", m_tdata[p*DW +: DW], expq[0].data);
            chk("tkeep", 64'(m_tkeep[p*KW +: KW]), 64'(expq[0].keep));
            chk("tlast", 64'(m_tlast[p]), 64'(expq[0].last));
         end
      end
      exp_rdy = rst && ((in_pkt && !fwd) || !(expq.size() > 0 && !r[expq[0].port]));
      chk("s_tready", 64'(s_tready), 64'(exp_rdy));
      chk("stat_in_packet", 64'(stat), 64'(rst && in_pkt));
      chk("drop_counter", 64'(drop_cnt), 64'(cnt_m));
      acc = s_tvalid && exp_rdy;
      drop_ev = 1'b0;
      if (!rst) begin
         expq.delete();
         in_pkt = 1'b0;
         fwd    = 1'b0;
         cnt_m  = '0;
      end else begin
         if (expq.size() > 0 && r[expq[0].port]) void'(expq.pop_front());
         if (acc) begin
            if (!in_pkt) begin
               fwd      = (s_tdest < 2'd3) ? cfg_en[s_tdest] : 1'b0;
               cur_port = s_tdest;
               drop_ev  = !fwd;
            end
            if (fwd) expq.push_back('{port: cur_port, data: s_tdata, keep: s_tkeep, last: s_tlast});
            in_pkt = !s_tlast;
         end
         if (cfg_rst)                       cnt_m = '0;
         else if (drop_ev && cnt_m != 4'hf) cnt_m = cnt_m + 4'd1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      bit acc;
      s_tvalid = 1'b0;
      repeat (n) cycle(acc);
   endtask

   task automatic send_beat(input logic [1:0] dest, input bit last, input int gap);
      bit acc;
      int n;
      s_tvalid = 1'b0;
      repeat (gap) begin
         s_tdest = 2'($urandom);
         cycle(acc);
      end
      s_tvalid = 1'b1;
      s_tdest  = dest;
      s_tdata  = {$urandom, $urandom};
      s_tkeep  = 8'($urandom);
      s_tlast  = last;
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 100) begin
         cycle(acc);
         n++;
      end
      chk("accept_within_budget", 64'(acc), 64'(1));
      s_tvalid = 1'b0;
   endtask

   task automatic send_pkt(input logic [1:0] dest, input int len, input int gap);
      for (int b = 0; b < len; b++)
         send_beat((b == 0) ? dest : 2'($urandom), b == len - 1, gap);
   endtask

   initial begin
      bit acc;
      rst = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0; s_tdest = '0;
      m_tready = '1; cfg_en = 3'b111; cfg_rst = 1'b0; rdy_rand = 1'b0;
      in_pkt = 1'b0; fwd = 1'b0; cur_port = '0; cnt_m = '0;
      @(posedge clk);
      #1;
      s_tvalid = 1'b1;
      cycle(acc);
      cycle(acc);
      s_tvalid = 1'b0;
      rst = 1'b1;
      idle(2);

      // Routing, back-to-back packets to different ports.
      send_pkt(2'd2, 3, 0);
      send_pkt(2'd0, 1, 0);
      send_pkt(2'd1, 2, 0);
      idle(3);
      chk("route_drop_counter", 64'(drop_cnt), 64'(0));

      // Out-of-range destination, then a normal packet.
      send_pkt(2'd3, 4, 0);
      send_pkt(2'd1, 2, 0);
      idle(3);
      chk("invalid_dest_drops", 64'(drop_cnt), 64'(1));

      // Disabled port re-enabled mid-packet: packet stays dropped.
      cfg_en = 3'b101;
      send_beat(2'd1, 1'b0, 0);
      cfg_en = 3'b111;
      send_beat(2'd1, 1'b0, 0);
      send_beat(2'd0, 1'b1, 0);
      idle(3);
      chk("disabled_port_drops", 64'(drop_cnt), 64'(2));

      // Backpressure on port 0.
      rdy_pat.push_back(3'b111);
      rdy_pat.push_back(3'b110);
      rdy_pat.push_back(3'b110);
      rdy_pat.push_back(3'b111);
      send_pkt(2'd0, 5, 0);
      idle(3);

      // Reset in the middle of a packet.
      send_beat(2'd1, 1'b0, 0);
      send_beat(2'd0, 1'b0, 0);
      rst = 1'b0;
      s_tvalid = 1'b1;
      cycle(acc);
      s_tvalid = 1'b0;
      rst = 1'b1;
      chk("reset_drop_counter", 64'(drop_cnt), 64'(0));
      chk("reset_tvalid", 64'(m_tvalid), 64'(0));
      send_pkt(2'd0, 2, 0);
      send_pkt(2'd2, 1, 0);
      idle(3);

      // Counter saturation and clear priority.
      repeat (17) send_pkt(2'd3, 1, 0);
      idle(2);
      chk("drop_saturated", 64'(drop_cnt), 64'(15));
      cfg_rst = 1'b1;
      send_beat(2'd3, 1'b1, 0);
      cfg_rst = 1'b0;
      chk("clear_beats_increment", 64'(drop_cnt), 64'(0));
      send_pkt(2'd3, 2, 0);
      idle(2);
      chk("count_after_clear", 64'(drop_cnt), 64'(1));

      // Randomized traffic with random backpressure and enables.
      rdy_rand = 1'b1;
      for (int k = 0; k < 300; k++) begin
         if ($urandom_range(0, 7) == 0) cfg_en = 3'($urandom);
         send_pkt(2'($urandom), $urandom_range(1, 4), $urandom_range(0, 2));
      end
      rdy_rand = 1'b0;
      idle(5);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/axis_tdest_demux_param.md
# axis_tdest_demux_param

Parametrised AXI-Stream tdest demultiplexer, the successor to the fixed three-output scheduler demux. It sits between the packet dispatcher and the per-interface TX FIFOs. It routes each whole packet to one of M_COUNT outputs, selected by the tdest value on the packet's first beat. Packets whose destination is out of range or whose output is disabled are dropped and counted. A registered output stage gives one-cycle latency at full throughput.

## Interface
- M_COUNT, 3: number of master outputs (1..16)
- AXIS_DATA_WIDTH, 64: tdata width
- AXIS_KEEP_WIDTH, AXIS_DATA_WIDTH/8: tkeep width
- AXIS_DEST_WIDTH, 2: tdest width; must satisfy 2**AXIS_DEST_WIDTH >= M_COUNT
- DROP_COUNTER_WIDTH, 32: width of the dropped-packet counter
- clk  in  1  single clock
- rst  in  1  reset, synchronous and active-low
- s_axis_tdata  in  AXIS_DATA_WIDTH  input data
- s_axis_tkeep  in  AXIS_KEEP_WIDTH  input byte enables
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- s_axis_tlast  in  1  end of packet
- s_axis_tdest  in  AXIS_DEST_WIDTH  destination; sampled on the first beat only
- m_axis_tdata  out  M_COUNT*AXIS_DATA_WIDTH  flat; port i occupies slice [i*W +: W]
- m_axis_tkeep  out  M_COUNT*AXIS_KEEP_WIDTH  flat
- m_axis_tvalid  out  M_COUNT  per-port valid
- m_axis_tready  in  M_COUNT  per-port ready
- m_axis_tlast  out  M_COUNT  per-port last
- cfg_port_enable  in  M_COUNT  bit i=1 allows routing to port i
- cfg_rst_drop_counter  in  1  synchronous clear of drop_counter
- drop_counter  out  DROP_COUNTER_WIDTH  number of dropped packets; saturating
- stat_in_packet  out  1  high while inside a packet (state FORWARD or DROP)

## Operation
- Input FSM states:
  - IDLE: waiting for the first beat of a packet.
  - FORWARD: routing the remaining beats to the latched port sel.
  - DROP: discarding the remaining beats.
- First-beat decision, taken in IDLE when a beat is accepted:
  - If tdest < M_COUNT and cfg_port_enable[tdest]=1: sel := tdest. The beat goes to the output slot. Next state is FORWARD, or stays IDLE if tlast.
  - Otherwise: the beat is discarded and drop_counter increments. Next state is DROP, or stays IDLE if tlast.
- FORWARD: every accepted beat goes to port sel. tdest on these beats is ignored. tlast returns the FSM to IDLE.
- DROP: every beat is accepted and discarded. tlast returns the FSM to IDLE.
- The destination is decided once per packet. A change to cfg_port_enable mid-packet does not affect the current packet.
- Output slot: a single register holding {data, keep, last, port}, plus out_valid.
  - m_axis_tvalid[i] = out_valid && out_port==i.
  - m_axis_tdata, tkeep and tlast of port i carry the slot contents. Their value is don't-care when tvalid[i]=0.
- drop_counter:
  - Saturates at all-ones.
  - cfg_rst_drop_counter has priority over a simultaneous increment; the result is 0.

## Timing
- Reset (rst=0 sampled at a clk edge):
  - State goes to IDLE, out_valid=0, drop_counter=0.
  - While rst=0: s_axis_tready=0, all m_axis_tvalid=0, stat_in_packet=0.
- Reset mid-packet: the partial packet and the slot contents are lost. The first beat accepted after reset is treated as a new first beat.
- s_axis_tready is combinational:
  - In IDLE and FORWARD: !out_valid || m_axis_tready[out_port].
  - In DROP: 1.
- Latency: a beat accepted at edge N is presented on m_axis at cycle N+1.
- Throughput: one beat per cycle when the selected port holds tready=1.
- Backpressure:
  - m_axis_tready[out_port]=0 holds the slot and all its signals stable, and holds s_axis_tready low.
  - tready on non-selected ports is ignored.
- Slot handoff: a slot drain and a load in the same cycle are allowed. This also holds when the new beat targets a different port (back-to-back packets to different ports, no bubble).
- Drop of a first beat in IDLE still requires the slot to be free or draining. This keeps packet order toward the TX FIFOs.
- AXI-Stream rule: m_axis_tvalid never deasserts without a handshake.

## Test plan
- Routing with all ports enabled, ready=1:
  - Stimulus: 3-beat packet tdest=2, then 1-beat packet tdest=0, then 2-beat packet tdest=1.
  - Required: each port gets exactly its beats, data intact, tlast on the final beat; port 0 valid on the cycle after port 2's last beat (no bubble); drop_counter=0.
- Invalid destination, M_COUNT=3:
  - Stimulus: 4-beat packet tdest=3.
  - Required: no m_axis_tvalid; s_axis_tready=1 for beats 2-4; drop_counter=1; a following packet tdest=1 is forwarded normally.
- Disabled port:
  - Stimulus: cfg_port_enable=3'b101, packet tdest=1 dropped; then cfg_port_enable=3'b111 mid-packet.
  - Required: the rest of that packet is still dropped; drop_counter=1.
- Backpressure:
  - Stimulus: m_axis_tready[0] toggling 1,0,0,1 during a 5-beat tdest=0 packet.
  - Required: beats in order; slot signals stable while tready=0; s_axis_tready=0 in those cycles.
- Reset mid-packet:
  - Stimulus: rst=0 for 1 cycle after beat 2 of 4 (tdest=1).
  - Required: all tvalid=0 and drop_counter=0 next cycle; the next beat is treated as a first beat and routed by its own tdest.
- Counter:
  - Stimulus: DROP_COUNTER_WIDTH=4 with 17 dropped packets.
  - Required: drop_counter saturates at 15; asserting cfg_rst_drop_counter in the same cycle as a drop gives 0.
